fifo_byte_serializer: RTL and testbench

- Downstream consumer of the 64-bit test-pattern FIFO in the DE2-115 demo. Pops one word at a time through the FIFO read port (rden/dout/empty).
- Splits each word into bytes, least-significant byte first. An optional sync header byte can be prefixed to each word.
- Presents bytes on a valid/ready byte stream toward the UART TX. Keeps a running count of words sent.

---
 rtl/fifo_byte_serializer.sv | 145 ++++++++++++++
 tb/tb_fifo_byte_serializer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_byte_serializer.sv
// -----------------------------------------------------------------------------
// fifo_byte_serializer
//
// Pops WIDTH-bit words from a FIFO read port and sends each one as a byte
// stream, least-significant byte first, optionally led by a sync header byte.
// Keeps a running count of words whose last byte has been accepted.
//
// Parameters
//   WIDTH      FIFO word width in bits (multiple of 8, >= 8)
//   HEADER_EN  1: prefix HEADER to every word
//   HEADER     sync header byte value
//
// Ports
//   iclk         clock, rising edge
//   irst         asynchronous active-high reset
//   ififo_empty  FIFO empty flag
//   ofifo_rden   FIFO read strobe (registered, only ever high in IDLE)
//   ififo_dout   FIFO read data, valid the cycle after a read
//   otx_data     byte toward the transmitter
//   otx_valid    otx_data valid
//   itx_ready    transmitter accepts when otx_valid && itx_ready
//   obusy        high whenever a word is in progress (state != IDLE)
//   owords       number of completely transmitted words (wraps at 2^32)
// -----------------------------------------------------------------------------
module fifo_byte_serializer #(
    parameter int unsigned WIDTH     = 64,
    parameter bit          HEADER_EN = 1'b1,
    parameter logic [7:0]  HEADER    = 8'hA5
) (
    input  logic             iclk,
    input  logic             irst,
    input  logic             ififo_empty,
    output logic             ofifo_rden,
    input  logic [WIDTH-1:0] ififo_dout,
    output logic [7:0]       otx_data,
    output logic             otx_valid,
    input  logic             itx_ready,
    output logic             obusy,
    output logic [31:0]      owords
);

    localparam int unsigned NB = WIDTH / 8;
    localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

    generate
        if (((WIDTH % 8) != 0) || (WIDTH < 8)) begin : g_bad_width
            $error("fifo_byte_serializer: WIDTH must be a non-zero multiple of 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HDR,
        ST_SEND
    } state_t;

    state_t           r_state;
    logic             r_rden;
    logic [7:0]       r_data;
    logic             r_valid;
    logic [31:0]      r_words;
    logic [WIDTH-1:0] r_shreg;
    logic [IW-1:0]    r_idx;

    logic [WIDTH-1:0] w_shreg_shifted;
    logic             w_last_byte;

    assign w_shreg_shifted = r_shreg >> 8;
    assign w_last_byte     = (r_idx == IW'(NB - 1));

    // ofifo_rden is registered, so the decision to read is taken one edge
    // early: on entry to IDLE from the last byte (keeps back-to-back words to
    // exactly two idle cycles) or while waiting in IDLE. The read only counts
    // if the FIFO is still non-empty in the IDLE cycle itself.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_state <= ST_IDLE;
            r_rden  <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_words <= '0;
            r_shreg <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_rden && !ififo_empty) begin
                        r_rden  <= 1'b0;
                        r_state <= ST_WAIT;
                    end else begin
                        r_rden  <= !ififo_empty;
                    end
                end

                ST_WAIT: begin
                    r_shreg <= ififo_dout;
                    r_idx   <= '0;
                    r_valid <= 1'b1;
                    if (HEADER_EN) begin
                        r_data  <= HEADER;
                        r_state <= ST_HDR;
                    end else begin
                        r_data  <= ififo_dout[7:0];
                        r_state <= ST_SEND;
                    end
                end

                ST_HDR: begin
                    if (itx_ready) begin
                        r_data  <= r_shreg[7:0];
                        r_state <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (itx_ready) begin
                        r_shreg <= w_shreg_shifted;
                        r_idx   <= r_idx + IW'(1);
                        if (w_last_byte) begin
                            r_valid <= 1'b0;
                            r_data  <= '0;
                            r_words <= r_words + 32'd1;
                            r_rden  <= !ififo_empty;
                            r_state <= ST_IDLE;
                        end else begin
                            r_data  <= w_shreg_shifted[7:0];
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ofifo_rden = r_rden;
    assign otx_data   = r_data;
    assign otx_valid  = r_valid;
    assign obusy      = (r_state != ST_IDLE);
    assign owords     = r_words;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// -----------------------------------------------------------------------------
// tb_fifo_byte_serializer
//
// Drives a default-parameter serializer (64-bit, header A5) from a queue-based
// FIFO model and compares the byte stream against bytes precomputed per word,
// plus a 16-bit headerless instance for the narrow-word case.
// -----------------------------------------------------------------------------
module tb_fifo_byte_serializer;

    logic        iclk;
    logic        irst;
    logic        ififo_empty;
    logic        ofifo_rden;
    logic [63:0] ififo_dout;
    logic [7:0]  otx_data;
    logic        otx_valid;
    logic        itx_ready;
    logic        obusy;
    logic [31:0] owords;

    logic        e16;
    logic        rd16;
    logic [15:0] d16;
    logic [7:0]  dt16;
    logic        v16;
    logic        r16;
    logic        busy16;
    logic [31:0] owords16;

    fifo_byte_serializer u_dut (
        .iclk        (iclk),
        .irst        (irst),
        .ififo_empty (ififo_empty),
        .ofifo_rden  (ofifo_rden),
        .ififo_dout  (ififo_dout),
        .otx_data    (otx_data),
        .otx_valid   (otx_valid),
        .itx_ready   (itx_ready),
        .obusy       (obusy),
        .owords      (owords)
    );

    fifo_byte_serializer #(
        .WIDTH     (16),
        .HEADER_EN (1'b0),
        .HEADER    (8'hA5)
    ) u_dut16 (
        .iclk        (iclk),
        .irst        (irst),
        .ififo_empty (e16),
        .ofifo_rden  (rd16),
        .ififo_dout  (d16),
        .otx_data    (dt16),
        .otx_valid   (v16),
        .itx_ready   (r16),
        .obusy       (busy16),
        .owords      (owords16)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    int          errors = 0;
    int          checks = 0;

    logic [63:0] fq[$];
    logic [7:0]  exp_q[$];
    bit          last_q[$];
    int unsigned exp_words = 0;
    bit          inflight = 0;
    bit          want_first = 0;
    bit          gap_exp = 0;
    bit          prev_hold = 0;
    logic [7:0]  prev_d = '0;
    int          cyc = 0;
    int          rden_cyc = 0;
    int          last_cyc = 0;
    int          bytes_acc = 0;
    int          rden_pulses = 0;

    logic [15:0] q16[$];
    int          rc16[$];
    int          bc16[$];
    logic [7:0]  bv16[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word goes into the FIFO; its framed byte sequence goes into the expectation.
    task automatic push(input logic [63:0] w);
        fq.push_back(w);
        exp_q.push_back(8'hA5);
        last_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(w[8*i +: 8]);
            last_q.push_back(i == 7);
        end
    endtask

    function automatic bit pick(input int mode, input int i);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((i % 3) == 0);
        return ($urandom_range(0, 3) != 0);
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input bit rdy);
        logic       v;
        logic       rd;
        logic       emp;
        logic [7:0] d;
        logic [7:0] eb;
        bit         lb;
        itx_ready   = rdy;
        emp         = (fq.size() == 0);
        ififo_empty = emp;
        v  = otx_valid;
        d  = otx_data;
        rd = ofifo_rden;
        if (prev_hold) begin
            check("hold_valid", 64'(v), 64'(1));
            check("hold_data", 64'(d), 64'(prev_d));
        end
        if (rd) begin
            check("rden_only_when_idle", 64'({inflight, v}), 64'(0));
            if (!emp) begin
                inflight   = 1'b1;
                want_first = 1'b1;
                rden_cyc   = cyc;
                rden_pulses++;
            end
        end
        if (v && want_first) begin
            check("first_latency", 64'(cyc - rden_cyc), 64'(2));
            if (gap_exp) check("word_gap", 64'(cyc - last_cyc), 64'(3));
            want_first = 1'b0;
            gap_exp    = 1'b0;
        end
        if (v && rdy) begin
            if (exp_q.size() == 0) begin
                check("extra_byte", 64'(v), 64'(0));
            end else begin
                eb = exp_q.pop_front();
                lb = last_q.pop_front();
                bytes_acc++;
                check("byte", 64'(d), 64'(eb));
                if (lb) begin
                    exp_words++;
                    inflight = 1'b0;
                    last_cyc = cyc;
                    gap_exp  = !emp;
                end
            end
        end
        prev_hold = v && !rdy;
        prev_d    = d;
        @(posedge iclk);
        if (rd && !emp) ififo_dout = fq.pop_front();
        @(negedge iclk);
        cyc++;
        check("owords", 64'(owords), 64'(exp_words));
    endtask

    task automatic run(input int mode, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !inflight && fq.size() == 0) break;
            step(pick(mode, i));
        end
        repeat (2) step(1'b1);
        check("drain", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        irst        = 1'b1;
        ififo_empty = 1'b1;
        ififo_dout  = '0;
        itx_ready   = 1'b0;
        e16         = 1'b1;
        d16         = '0;
        r16         = 1'b1;
        repeat (2) @(negedge iclk);

        // Reset state
        check("rst_outputs", 64'({ofifo_rden, otx_valid, obusy}), 64'(0));
        check("rst_data", 64'(otx_data), 64'(0));
        check("rst_words", 64'(owords), 64'(0));
        check("rst16_outputs", 64'({rd16, v16, busy16, owords16}), 64'(0));
        irst = 1'b0;
        @(negedge iclk);

        // Empty FIFO for 100 cycles: nothing moves whatever ready does
        for (int i = 0; i < 100; i++) begin
            ififo_empty = 1'b1;
            itx_ready   = 1'($urandom_range(0, 1));
            @(negedge iclk);
            cyc++;
            check("empty_quiet", 64'({ofifo_rden, otx_valid, obusy}), 64'(0));
        end

        // Basic word, ready high
        rden_pulses = 0;
        push(64'h0807060504030201);
        run(0, 60);
        check("basic_word_cycles", 64'(last_cyc - rden_cyc), 64'(10));
        check("basic_rden_pulses", 64'(rden_pulses), 64'(1));
        check("basic_words", 64'(owords), 64'(1));

        // Same word under ready pattern 1,0,0,...
        rden_pulses = 0;
        push(64'h0807060504030201);
        run(1, 200);
        check("bp_rden_pulses", 64'(rden_pulses), 64'(1));
        check("bp_words", 64'(owords), 64'(2));

        // Three back-to-back words
        bytes_acc = 0;
        push(64'd0);
        push(64'd1);
        push(64'd2);
        run(0, 100);
        check("btb_bytes", 64'(bytes_acc), 64'(27));
        check("btb_words", 64'(owords), 64'(5));

        // Asynchronous reset after byte 03 of a word; a second word waits behind it
        bytes_acc = 0;
        push(64'h0807060504030201);
        push(64'h1122334455667788);
        for (int i = 0; i < 40 && bytes_acc < 4; i++) step(1'b1);
        check("rst_reach_byte03", 64'(bytes_acc), 64'(4));
        check("pre_rst_valid", 64'(otx_valid), 64'(1));
        irst = 1'b1;
        #1;
        check("rst_async_valid", 64'(otx_valid), 64'(0));
        check("rst_async_words", 64'(owords), 64'(0));
        check("rst_async_busy", 64'(obusy), 64'(0));
        if (inflight) begin
            while (last_q.size() != 0) begin
                void'(exp_q.pop_front());
                if (last_q.pop_front()) break;
            end
        end
        inflight   = 1'b0;
        want_first = 1'b0;
        gap_exp    = 1'b0;
        prev_hold  = 1'b0;
        exp_words  = 0;
        #1;
        irst = 1'b0;
        @(negedge iclk);
        cyc++;
        run(0, 60);
        check("post_rst_words", 64'(owords), 64'(1));

        // Random words pushed while busy, random backpressure
        for (int k = 0; k < 15; k++) begin
            push({$urandom, $urandom});
            repeat ($urandom_range(0, 12)) step(pick(2, 0));
        end
        run(2, 3000);
        check("rand_words", 64'(owords), 64'(16));

        // 16-bit headerless instance: two words, ready high
        q16.push_back(16'hBEEF);
        q16.push_back(16'h1234);
        for (int i = 0; i < 30; i++) begin
            logic rdl;
            logic el;
            el  = (q16.size() == 0);
            e16 = el;
            rdl = rd16;
            if (rdl && !el) rc16.push_back(i);
            if (v16) begin
                bv16.push_back(dt16);
                bc16.push_back(i);
            end
            @(posedge iclk);
            if (rdl && !el) d16 = q16.pop_front();
            @(negedge iclk);
        end
        check("w16_nbytes", 64'(bv16.size()), 64'(4));
        check("w16_nreads", 64'(rc16.size()), 64'(2));
        check("w16_b0", 64'(bv16[0]), 64'(8'hEF));
        check("w16_b1", 64'(bv16[1]), 64'(8'hBE));
        check("w16_b2", 64'(bv16[2]), 64'(8'h34));
        check("w16_b3", 64'(bv16[3]), 64'(8'h12));
        check("w16_first_latency", 64'(bc16[0] - rc16[0]), 64'(2));
        check("w16_word_cycles", 64'(bc16[1] - rc16[0]), 64'(3));
        check("w16_period", 64'(bc16[2] - bc16[0]), 64'(4));
        check("w16_words", 64'(owords16), 64'(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
